fetch_ctrl: RTL and testbench

Fetch sequencer for the multi-cycle RISC-V subset core. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds each fetched instruction for decode until decode accepts it. It applies branch/jump redirects from execute and halts on a misaligned redirect target.

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_ctrl.sv | 95 +++++++++
 tb/tb_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RISC-V subset core.
// Imported by the fetch sequencer and any block that observes its state.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the pc, reads instruction memory over req/ack and
// holds each instruction for decode; execute redirects override everything.
module fetch_ctrl
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_data,
  output logic [XLEN-1:0]    inst_pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  output logic               fetch_fault,
  output fetch_state_t       dbg_state
);

  // Handshakes: a transfer happens at a posedge where the producer's
  // valid/req and the consumer's ready/ack are both high. imem_req and
  // inst_valid depend only on state, never on the same-cycle ack/ready.

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     data_q, data_d;
  logic [XLEN-1:0] ipc_q, ipc_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    ipc_d   = ipc_q;

    case (state_q)
      IDLE: begin
        if (fetch_en) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          data_d  = imem_rdata;
          ipc_d   = pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          pc_d    = pc_q + XLEN'(PC_STEP);
          state_d = fetch_en ? FETCH : IDLE;
        end
      end
      default: begin
      end
    endcase

    // Redirect overrides any transfer or handshake in the same cycle;
    // a misaligned target is recorded in pc and parks the sequencer.
    if (redirect_valid && (state_q != FAULT)) begin
      pc_d   = redirect_target;
      data_d = data_q;
      ipc_d  = ipc_q;
      if (redirect_target[1:0] != 2'b00) state_d = FAULT;
      else                               state_d = fetch_en ? FETCH : IDLE;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign inst_valid  = (state_q == HOLD);
  assign inst_data   = data_q;
  assign inst_pc     = ipc_q;
  assign fetch_fault = (state_q == FAULT);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_fetch_ctrl;
  import core_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         fetch_en;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst_data;
  logic [W-1:0] inst_pc;
  logic         redirect_valid;
  logic [W-1:0] redirect_target;
  logic         fetch_fault;
  fetch_state_t dbg_state;

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(W), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_fault(fetch_fault),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the pc the next fetch must use, whether a memory
  // request is outstanding, and the instruction waiting for decode.
  logic         m_known  = 1'b0;
  logic         m_fault  = 1'b0;
  logic         m_active = 1'b0;
  logic [W-1:0] m_pc     = '0;
  logic [31:0]  exp_data_q[$];
  logic [W-1:0] exp_pc_q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    if (!m_known) return;
    chk("m_req", W'(imem_req), W'(m_active && !m_fault));
    if (m_active && !m_fault) chk("m_addr", imem_addr, m_pc);
    chk("m_valid", W'(inst_valid), W'(exp_data_q.size() != 0));
    if (exp_data_q.size() != 0) begin
      chk("m_data", W'(inst_data), W'(exp_data_q[0]));
      chk("m_ipc", inst_pc, exp_pc_q[0]);
    end
    chk("m_fault", W'(fetch_fault), W'(m_fault));
  endtask

  task automatic model_update(input logic rn, input logic fe, input logic ack,
                              input logic [31:0] rd, input logic rdy,
                              input logic rv, input logic [W-1:0] rt);
    if (!rn) begin
      m_known = 1'b1; m_fault = 1'b0; m_active = 1'b0; m_pc = '0;
      exp_data_q.delete(); exp_pc_q.delete();
    end else if (m_fault) begin
    end else if (rv) begin
      exp_data_q.delete(); exp_pc_q.delete();
      m_pc = rt;
      if (rt[1:0] != 2'b00) begin m_fault = 1'b1; m_active = 1'b0; end
      else m_active = fe;
    end else if (m_active && ack) begin
      exp_data_q.push_back(rd); exp_pc_q.push_back(m_pc);
      m_active = 1'b0;
    end else if (exp_data_q.size() != 0 && rdy) begin
      void'(exp_data_q.pop_front()); void'(exp_pc_q.pop_front());
      m_pc = m_pc + 32'd4;
      m_active = fe;
    end else if (!m_active && exp_data_q.size() == 0 && fe) begin
      m_active = 1'b1;
    end
  endtask

  // One clock: check at negedge, drive, advance model, land #1 after posedge.
  task automatic step(input logic rn, input logic fe, input logic ack,
                      input logic [31:0] rd, input logic rdy,
                      input logic rv, input logic [W-1:0] rt);
    @(negedge clk);
    model_check();
    reset_n = rn; fetch_en = fe; imem_ack = ack; imem_rdata = rd;
    inst_ready = rdy; redirect_valid = rv; redirect_target = rt;
    model_update(rn, fe, ack, rd, rdy, rv, rt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [W-1:0] addrs[$];
    logic [31:0]  held_data;
    logic [W-1:0] held_pc;
    int           pulses;

    reset_n = 1'b0; fetch_en = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

    // Reset state
    do_reset();
    chk("rst_req", W'(imem_req), '0);
    chk("rst_valid", W'(inst_valid), '0);
    chk("rst_data", W'(inst_data), '0);
    chk("rst_ipc", inst_pc, '0);
    chk("rst_fault", W'(fetch_fault), '0);
    chk("rst_addr", imem_addr, '0);
    chk("rst_state", W'(dbg_state), W'(IDLE));

    // Zero-wait streaming: addresses 0,4,8 and one valid pulse per 2 cycles
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'h1000 + i, 1'b1, 1'b0, '0);
      if (imem_req) addrs.push_back(imem_addr);
      if (inst_valid) pulses++;
    end
    chk("stream_cnt", W'(addrs.size()), 32'd4);
    chk("stream_a0", addrs[0], 32'h0);
    chk("stream_a1", addrs[1], 32'h4);
    chk("stream_a2", addrs[2], 32'h8);
    chk("stream_pulses", W'(pulses), 32'd4);

    // Delayed ack: request held 4 cycles at address 0
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    chk("wait_req0", W'(imem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'hdead_beef, 1'b0, 1'b0, '0);
      chk("wait_req", W'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'h0);
    end
    step(1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b0, '0);
    chk("wait_valid", W'(inst_valid), 32'd1);
    chk("wait_data", W'(inst_data), 32'h0050_0093);
    chk("wait_ipc", inst_pc, 32'h0);

    // Decode stall: held instruction stays stable, no request
    held_data = inst_data; held_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, '0);
      chk("stall_valid", W'(inst_valid), 32'd1);
      chk("stall_data", W'(inst_data), W'(held_data));
      chk("stall_ipc", inst_pc, held_pc);
      chk("stall_req", W'(imem_req), '0);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);
    chk("stall_next_addr", imem_addr, 32'h4);
    chk("stall_next_req", W'(imem_req), 32'd1);

    // Redirect concurrent with ack: fetched data discarded
    step(1'b1, 1'b1, 1'b1, 32'hbad0_bad0, 1'b1, 1'b1, 32'h40);
    chk("redir_valid", W'(inst_valid), '0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_data_kept", W'(inst_data), 32'h0050_0093);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
    chk("redir_ipc", inst_pc, 32'h40);
    // Redirect concurrent with decode handshake: target wins, no +4
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
    chk("redir_hs_addr", imem_addr, 32'h80);
    chk("redir_hs_valid", W'(inst_valid), '0);

    // Misaligned redirect: sticky fault until reset
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h42);
    chk("fault_set", W'(fetch_fault), 32'd1);
    chk("fault_req", W'(imem_req), '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0);
      chk("fault_sticky", W'(fetch_fault), 32'd1);
      chk("fault_noreq", W'(imem_req), '0);
    end
    do_reset();
    chk("fault_clr", W'(fetch_fault), '0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", W'(imem_req), 32'd1);

    // pc wrap at top of address space
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0073, 1'b0, 1'b0, '0);
    chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);
    chk("wrap_addr", imem_addr, 32'h0);
    // Reset during FETCH drops the request; late ack ignored
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    chk("rst_fetch_req", W'(imem_req), '0);
    step(1'b1, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, '0);
    chk("late_ack_valid", W'(inst_valid), '0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic         r_rn, r_rv;
      logic [W-1:0] r_rt;
      r_rn = ($urandom_range(0, 99) != 0);
      r_rv = ($urandom_range(0, 15) == 0);
      r_rt = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 19) == 0) r_rt[1:0] = 2'($urandom_range(1, 3));
      if (m_fault && $urandom_range(0, 9) == 0) r_rn = 1'b0;
      step(r_rn, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), r_rv, r_rt);
    end
    @(negedge clk);
    model_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
